// File: rtl/spi_regfile_ext.sv
// SPI mode-0 peripheral fronting a small register file. Frames are checked when nCS rises.
// Accepted writes commit one clk later; rejected frames pulse frame_err and are counted.
module spi_regfile_ext #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err,
    output logic [7:0]                 err_count
);
    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_dly_q, ncs_dly_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME-1:0]    sh_q, sh_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                cipo_q, cipo_d;
    logic                rd_mode_q, rd_mode_d;
    logic                pend_q, pend_d;
    logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_q, err_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   cmd_addr, f_addr;
    logic [DATA_W-1:0]   f_data, rd_sel;
    logic                f_mode, sample, closing;
    logic [NUM_REGS-1:0] f_onehot;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q;

    // Shifter holds mode/addr/data in frame order; address alone sits in the low bits
    // right after the command phase.
    assign cmd_addr = sh_q[ADDR_W-1:0];
    assign f_mode   = sh_q[FRAME-1];
    assign f_addr   = sh_q[FRAME-2 -: ADDR_W];
    assign f_data   = sh_q[DATA_W-1:0];

    always_comb begin
        rd_sel   = '0;
        f_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(cmd_addr) == 32'(k)) rd_sel = regs_q[k];
            if (32'(f_addr) == 32'(k)) f_onehot[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
            sclk_dly_q  <= sclk_s;
            ncs_dly_q   <= ncs_s;
        end
    end

    assign sample  = sclk_rise & ~ncs_s & ((state_q == CMD) | (state_q == DATA));
    assign closing = ncs_rise & ((state_q == CMD) | (state_q == DATA));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rd_d        = rd_q;
        cipo_d      = cipo_q;
        rd_mode_d   = rd_mode_q;
        pend_d      = pend_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;
        err_d       = err_q;

        if (sample) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_FRAME) sh_d = {sh_q[FRAME-2:0], copi_s};
        end

        case (state_q)
            IDLE: begin
                if (ncs_fall || pend_q) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            CMD: begin
                if (ncs_rise) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_CMD) begin
                    state_d   = DATA;
                    rd_mode_d = ~sh_q[ADDR_W];
                    rd_d      = rd_sel;
                    cipo_d    = 1'b0;
                end
            end
            DATA: begin
                if (ncs_rise) begin
                    state_d = DONE;
                end else if (sclk_fall && !ncs_s) begin
                    cipo_d = rd_q[DATA_W-1];
                    rd_d   = rd_q << 1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (ncs_fall) pend_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // An empty frame (nCS pulse with no SCLK) is dropped without complaint.
        if (closing && cnt_q != '0) begin
            if (cnt_q == CNT_FRAME && |f_onehot) begin
                if (f_mode) wr_strobe_d = f_onehot;
            end else begin
                frame_err_d = 1'b1;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rd_q        <= '0;
            cipo_q      <= 1'b0;
            rd_mode_q   <= 1'b0;
            pend_q      <= 1'b0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
            err_q       <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rd_q        <= rd_d;
            cipo_q      <= cipo_d;
            rd_mode_q   <= rd_mode_d;
            pend_q      <= pend_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            err_q       <= err_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_strobe_d[k]) regs_q[k] <= f_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign err_count = err_q;
    assign CIPO_oe   = rd_mode_q & (state_q == DATA) & ~ncs_s;
    assign CIPO      = cipo_q & CIPO_oe;
endmodule

// File: tb/tb_spi_regfile_ext.sv
// Bench for spi_regfile_ext: default instance (a) plus a 3/16/8 instance (b) sharing SCLK/COPI,
// driven with directed and random frames and compared against a register-array model.
module tb_spi_regfile_ext;
    localparam int HALF = 6;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1;
    logic         cipo_a, oe_a, ferr_a, cipo_b, oe_b, ferr_b;
    logic [39:0]  regs_a;
    logic [127:0] regs_b;
    logic [4:0]   strb_a;
    logic [7:0]   strb_b, errc_a, errc_b;

    int n_tests = 0, n_fail = 0, b_act = 0;
    logic [15:0] mreg_a [5];
    logic [15:0] mreg_b [8];
    int merr_a = 0, merr_b = 0;

    always #5 clk = ~clk;

    spi_regfile_ext #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_a),
        .CIPO(cipo_a), .CIPO_oe(oe_a), .regs_flat(regs_a), .wr_strobe(strb_a),
        .frame_err(ferr_a), .err_count(errc_a));

    spi_regfile_ext #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(8), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_b),
        .CIPO(cipo_b), .CIPO_oe(oe_b), .regs_flat(regs_b), .wr_strobe(strb_b),
        .frame_err(ferr_b), .err_count(errc_b));

    always @(negedge clk) if (!rst && (strb_b != 8'd0 || ferr_b)) b_act++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_flat(input bit sel_b);
        logic [127:0] r;
        r = '0;
        if (sel_b) for (int k = 0; k < 8; k++) r[k*16 +: 16] = mreg_b[k];
        else       for (int k = 0; k < 5; k++) r[k*8 +: 8] = mreg_a[k][7:0];
        return r;
    endfunction

    task automatic set_ncs(input bit sel_b, input logic v);
        if (sel_b) ncs_b = v; else ncs_a = v;
    endtask

    task automatic xfer(input bit sel_b, input int nbits, input logic [63:0] bits, input bit keep_cs,
                        output logic [63:0] rx, output logic [63:0] oe);
        rx = '0;
        oe = '0;
        @(negedge clk);
        if (sel_b ? ncs_b : ncs_a) set_ncs(sel_b, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[62:0], sel_b ? cipo_b : cipo_a};
            oe = {oe[62:0], sel_b ? oe_b : oe_a};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (!keep_cs) set_ncs(sel_b, 1'b1);
    endtask

    // One complete frame plus its outcome. quick re-asserts nCS one clk after it rises,
    // so the following frame starts while the DUT is still finishing this one.
    task automatic do_frame(input bit sel_b, input bit mode, input int addr_in, input int data_in,
                            input int nbits, input bit quick);
        int aw, dw, nr, f, lat, addr, data;
        logic [63:0] full, bits, rx, oe, dmask, fmask;
        logic [127:0] got_strb;
        bit valid, wr, err, got_err;
        logic [15:0] rdv;
        aw = sel_b ? 3 : 7;
        dw = sel_b ? 16 : 8;
        nr = sel_b ? 8 : 5;
        f = 1 + aw + dw;
        lat = sel_b ? 4 : 3;
        addr = addr_in & ((1 << aw) - 1);
        data = data_in & ((1 << dw) - 1);
        dmask = (64'd1 << dw) - 64'd1;
        fmask = (64'd1 << f) - 64'd1;
        full = (64'(mode) << (aw + dw)) | (64'(addr) << dw) | 64'(data);
        if (nbits <= f) bits = full >> (f - nbits);
        else bits = (full << (nbits - f)) | (64'($urandom) & ((64'd1 << (nbits - f)) - 64'd1));
        valid = (nbits == f) && (addr < nr);
        wr = valid && mode;
        err = !valid && (nbits != 0);
        rdv = 16'h0;
        if (addr < nr) begin
            if (sel_b) rdv = mreg_b[addr];
            else rdv = mreg_a[addr];
        end
        xfer(sel_b, nbits, bits, 1'b0, rx, oe);
        if (nbits == f) begin
            check("cipo_oe", 128'(oe & fmask), 128'(mode ? 64'd0 : dmask));
            check("cipo_data", 128'(rx & fmask), 128'(mode ? 64'd0 : 64'(rdv)));
        end
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1 && quick) set_ncs(sel_b, 1'b0);
            got_strb = sel_b ? 128'(strb_b) : 128'(strb_a);
            got_err = sel_b ? ferr_b : ferr_a;
            if (c == lat) begin
                if (wr) begin
                    if (sel_b) mreg_b[addr] = 16'(data);
                    else mreg_a[addr] = 16'(data);
                end
                if (err) begin
                    if (sel_b) merr_b = (merr_b < 255) ? merr_b + 1 : 255;
                    else merr_a = (merr_a < 255) ? merr_a + 1 : 255;
                end
                check("wr_strobe", got_strb, wr ? (128'd1 << addr) : 128'd0);
                check("frame_err", 128'(got_err), 128'(err));
                check("regs_flat", sel_b ? regs_b : 128'(regs_a), model_flat(sel_b));
                check("err_count", 128'(sel_b ? errc_b : errc_a), 128'(sel_b ? merr_b : merr_a));
            end else begin
                check("pulse_quiet", got_strb | 128'(got_err), 128'd0);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) mreg_a[k] = 16'h0;
        for (int k = 0; k < 8; k++) mreg_b[k] = 16'h0;
        merr_a = 0;
        merr_b = 0;
    endtask

    initial begin
        logic [63:0] rx, oe;
        int r, nb;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_regs", 128'(regs_a) | regs_b, 128'd0);
        check("rst_pulses", 128'({strb_a, ferr_a, strb_b, ferr_b}), 128'd0);
        check("rst_cipo", 128'({cipo_a, oe_a, cipo_b, oe_b}), 128'd0);
        check("rst_errc", 128'({errc_a, errc_b}), 128'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_frame(1'b0, 1'b1, 0, 'h55, 16, 1'b0);
        check("wr_0x55", 128'(regs_a[7:0]), 128'h55);
        do_frame(1'b0, 1'b1, 4, 'hA3, 16, 1'b0);
        do_frame(1'b0, 1'b0, 4, 0, 16, 1'b0);
        do_frame(1'b0, 1'b1, 5, 'hAA, 16, 1'b0);
        do_frame(1'b0, 1'b1, 1, 'h3C, 15, 1'b0);
        do_frame(1'b0, 1'b1, 1, 'h3C, 17, 1'b0);
        check("err_three", 128'(errc_a), 128'd3);
        do_frame(1'b0, 1'b0, 6, 0, 16, 1'b0);
        do_frame(1'b0, 1'b1, 2, 0, 0, 1'b0);
        do_frame(1'b0, 1'b1, 3, 'h5A, 16, 1'b1);
        do_frame(1'b0, 1'b1, 2, 'h77, 16, 1'b0);
        do_frame(1'b0, 1'b0, 3, 0, 16, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) nb = 16;
            else if (r == 7) nb = 0;
            else if (r == 8) nb = 17;
            else nb = int'($urandom_range(1, 15));
            do_frame(1'b0, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 7)),
                     int'($urandom), nb, ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 300; i++) do_frame(1'b0, 1'b1, 0, 0, 1, 1'b0);
        check("err_sat", 128'(errc_a), 128'd255);
        check("b_idle_under_sclk", 128'(b_act), 128'd0);
        check("b_regs_idle", regs_b, 128'd0);

        xfer(1'b0, 9, 64'h102 >> 0, 1'b1, rx, oe);
        @(negedge clk);
        rst = 1'b1;
        ncs_a = 1'b1;
        sclk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_regs", 128'(regs_a), 128'd0);
        check("midrst_out", 128'({strb_a, ferr_a, cipo_a, oe_a, errc_a}), 128'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(1'b0, 1'b1, 2, 'h99, 16, 1'b0);
        check("post_rst_wr", 128'(regs_a[23:16]), 128'h99);

        do_frame(1'b1, 1'b1, 7, 'hBEEF, 20, 1'b0);
        check("sweep_reg7", 128'(regs_b[127:112]), 128'hBEEF);
        do_frame(1'b1, 1'b0, 7, 0, 20, 1'b0);
        for (int i = 0; i < 6; i++)
            do_frame(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
                     ($urandom_range(0, 3) == 0) ? 19 : 20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
